// File: rtl/imem_arbiter.sv
// Arbitrates the single-port instruction memory between IF fetch and the program loader.
// The loader has priority, bounded by a starvation counter, and can lock the memory for whole-image writes.
module imem_arbiter #(
  parameter int unsigned AW         = 16,
  parameter int unsigned DW         = 16,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [DW-1:0] f_rdata,
  output logic          cpu_hold,
  input  logic          l_valid,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_ready,
  input  logic          l_lock,
  output logic          l_locked,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CW = 4;

  typedef enum logic {
    RUN  = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   starve_q, starve_d;
  logic            f_rvalid_q, f_rvalid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      starve_q   <= '0;
      f_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      f_rvalid_q <= f_rvalid_d;
    end
  end

  // Grant selection, starvation tracking and lock transitions.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    l_ready  = 1'b0;
    f_gnt    = 1'b0;
    if (!rst) begin
      case (state_q)
        RUN: begin
          if (l_valid && (!f_req || (starve_q < CW'(STARVE_MAX)))) begin
            l_ready = 1'b1;
          end else if (f_req) begin
            f_gnt = 1'b1;
          end
          if (f_gnt || !f_req) begin
            starve_d = '0;
          end else if (l_ready && (starve_q < CW'(STARVE_MAX))) begin
            starve_d = starve_q + CW'(1);
          end
          if (l_lock) begin
            state_d = LOCK;
          end
        end
        LOCK: begin
          l_ready  = l_valid;
          starve_d = '0;
          if (!l_lock && !l_valid) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d  = RUN;
          starve_d = '0;
        end
      endcase
    end
    f_rvalid_d = f_gnt;
  end

  // Memory port mux; the write beat wins because grants are exclusive.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (l_ready) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = l_addr;
      mem_wdata = l_wdata;
    end else if (f_gnt) begin
      mem_en   = 1'b1;
      mem_addr = f_addr;
    end
  end

  assign cpu_hold = f_req & ~f_gnt;
  assign f_rvalid = f_rvalid_q;
  assign f_rdata  = mem_rdata;
  assign l_locked = (state_q == LOCK);

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a small synchronous memory model on the memory port.
module tb_imem_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_gnt;
  logic          f_rvalid;
  logic [DW-1:0] f_rdata;
  logic          cpu_hold;
  logic          l_valid;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic          l_ready;
  logic          l_lock;
  logic          l_locked;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] mem [0:255];

  int n_cmp = 0;
  int n_err = 0;

  imem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .cpu_hold(cpu_hold),
    .l_valid(l_valid), .l_addr(l_addr), .l_wdata(l_wdata), .l_ready(l_ready),
    .l_lock(l_lock), .l_locked(l_locked),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous-read memory
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; returns at the following negedge with the new registered state visible.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic fr, input logic [AW-1:0] fa,
                       input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] lw,
                       input logic lk);
    rst = r; f_req = fr; f_addr = fa; l_valid = lv; l_addr = la; l_wdata = lw; l_lock = lk;
    #1;
  endtask

  logic [9:0] exp_l;

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 16'h3260 + 16'(k);
    mem_rdata = '0;
    drive(1'b1, 1'b1, 16'h0, 1'b1, 16'h40, 16'hDEAD, 1'b0);

    // Reset with both requesters active
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b1, 16'h0, 1'b1, 16'h40, 16'hDEAD, 1'b0);
      check_eq("rst_f_gnt", 32'(f_gnt), 32'd0);
      check_eq("rst_l_ready", 32'(l_ready), 32'd0);
      check_eq("rst_mem_en", 32'(mem_en), 32'd0);
      check_eq("rst_mem_we", 32'(mem_we), 32'd0);
      cyc();
      check_eq("rst_f_rvalid", 32'(f_rvalid), 32'd0);
      check_eq("rst_l_locked", 32'(l_locked), 32'd0);
    end
    check_eq("rst_beat_not_written", 32'(mem[8'h40]), 32'h32A0);

    // Fetch-only stream over addresses 0..13
    for (int i = 0; i < 14; i++) begin
      drive(1'b0, 1'b1, 16'(i), 1'b0, 16'h0, 16'h0, 1'b0);
      check_eq("fetch_gnt", 32'(f_gnt), 32'd1);
      check_eq("fetch_hold", 32'(cpu_hold), 32'd0);
      check_eq("fetch_mem_addr", 32'(mem_addr), 32'(i));
      check_eq("fetch_mem_we", 32'(mem_we), 32'd0);
      cyc();
      check_eq("fetch_rvalid", 32'(f_rvalid), 32'd1);
      check_eq("fetch_rdata", 32'(f_rdata), 32'h3260 + 32'(i));
    end

    // Starvation bound: L,L,L,L,F repeating
    exp_l = 10'b0111101111;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 16'h0, 1'b1, 16'h20 + 16'(i), 16'hA000 + 16'(i), 1'b0);
      check_eq("starve_l_ready", 32'(l_ready), 32'(exp_l[i]));
      check_eq("starve_f_gnt", 32'(f_gnt), 32'(!exp_l[i]));
      check_eq("starve_hold", 32'(cpu_hold), 32'(exp_l[i]));
      cyc();
    end
    check_eq("starve_wr_0x20", 32'(mem[8'h20]), 32'hA000);
    check_eq("starve_wr_0x28", 32'(mem[8'h28]), 32'hA008);

    // Lock: three beats with fetch pending throughout
    drive(1'b0, 1'b1, 16'h0, 1'b1, 16'h0010, 16'hC502, 1'b1);
    check_eq("lock_enter_ready", 32'(l_ready), 32'd1);
    check_eq("lock_enter_fgnt", 32'(f_gnt), 32'd0);
    check_eq("lock_enter_locked", 32'(l_locked), 32'd0);
    cyc();
    check_eq("lock_locked_b1", 32'(l_locked), 32'd1);
    drive(1'b0, 1'b1, 16'h0, 1'b1, 16'h0011, 16'hC503, 1'b1);
    check_eq("lock_b1_ready", 32'(l_ready), 32'd1);
    check_eq("lock_b1_fgnt", 32'(f_gnt), 32'd0);
    check_eq("lock_b1_hold", 32'(cpu_hold), 32'd1);
    check_eq("lock_b1_wdata", 32'(mem_wdata), 32'hC503);
    cyc();
    drive(1'b0, 1'b1, 16'h0, 1'b1, 16'h0012, 16'hC504, 1'b0);
    check_eq("lock_b2_ready", 32'(l_ready), 32'd1);
    check_eq("lock_b2_fgnt", 32'(f_gnt), 32'd0);
    check_eq("lock_b2_addr", 32'(mem_addr), 32'h0012);
    cyc();
    check_eq("lock_still_locked", 32'(l_locked), 32'd1);
    drive(1'b0, 1'b1, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
    check_eq("lock_exit_fgnt", 32'(f_gnt), 32'd0);
    check_eq("lock_exit_hold", 32'(cpu_hold), 32'd1);
    check_eq("lock_exit_mem_en", 32'(mem_en), 32'd0);
    cyc();
    check_eq("lock_run_locked", 32'(l_locked), 32'd0);
    drive(1'b0, 1'b1, 16'h0010, 1'b0, 16'h0, 16'h0, 1'b0);
    check_eq("lock_run_fgnt", 32'(f_gnt), 32'd1);
    cyc();
    check_eq("lock_rd_rvalid", 32'(f_rvalid), 32'd1);
    check_eq("lock_rd_rdata", 32'(f_rdata), 32'hC502);
    drive(1'b0, 1'b1, 16'h0012, 1'b0, 16'h0, 16'h0, 1'b0);
    cyc();
    check_eq("lock_rd2_rdata", 32'(f_rdata), 32'hC504);

    // Write then fetch same address back-to-back
    drive(1'b0, 1'b0, 16'h0, 1'b1, 16'h0005, 16'h1200, 1'b0);
    check_eq("wtf_ready", 32'(l_ready), 32'd1);
    check_eq("wtf_we", 32'(mem_we), 32'd1);
    cyc();
    drive(1'b0, 1'b1, 16'h0005, 1'b0, 16'h0, 16'h0, 1'b0);
    check_eq("wtf_fgnt", 32'(f_gnt), 32'd1);
    cyc();
    check_eq("wtf_rvalid", 32'(f_rvalid), 32'd1);
    check_eq("wtf_rdata", 32'(f_rdata), 32'h1200);

    // Idle cycle drives nothing
    drive(1'b0, 1'b0, 16'h0077, 1'b0, 16'h0066, 16'h5555, 1'b0);
    check_eq("idle_mem_en", 32'(mem_en), 32'd0);
    check_eq("idle_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("idle_hold", 32'(cpu_hold), 32'd0);
    cyc();
    check_eq("idle_rvalid", 32'(f_rvalid), 32'd0);

    // In-flight fetch dropped by reset
    drive(1'b0, 1'b1, 16'h0001, 1'b0, 16'h0, 16'h0, 1'b0);
    cyc();
    check_eq("inflight_rvalid", 32'(f_rvalid), 32'd1);
    drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
    cyc();
    check_eq("inflight_dropped", 32'(f_rvalid), 32'd0);

    // Reset while locked with a beat pending
    drive(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1);
    cyc();
    check_eq("rlock_locked", 32'(l_locked), 32'd1);
    drive(1'b1, 1'b0, 16'h0, 1'b1, 16'h0030, 16'hBEEF, 1'b1);
    check_eq("rlock_ready", 32'(l_ready), 32'd0);
    check_eq("rlock_mem_en", 32'(mem_en), 32'd0);
    cyc();
    check_eq("rlock_unlocked", 32'(l_locked), 32'd0);
    drive(1'b0, 1'b1, 16'h0002, 1'b0, 16'h0, 16'h0, 1'b0);
    check_eq("rlock_run_fgnt", 32'(f_gnt), 32'd1);
    cyc();
    check_eq("rlock_after_locked", 32'(l_locked), 32'd0);
    check_eq("rlock_beat_not_written", 32'(mem[8'h30]), 32'h3290);
    check_eq("rlock_rd_rdata", 32'(f_rdata), 32'h3262);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
